// File: rtl/sram_sdp_init_if.sv
// Write/read/clear port bundle for sram_sdp_init; the DUT side takes the slave modport.
interface sram_sdp_init_if #(
  parameter int nrOfAddressBits = 5,
  parameter int nrOfDataBits    = 32
) ();
  localparam int NB = nrOfDataBits / 8;

  logic                       writeEnable;
  logic [NB-1:0]              byteEnable;
  logic [nrOfAddressBits-1:0] writeAddress;
  logic [nrOfDataBits-1:0]    writeData;
  logic                       readEnable;
  logic [nrOfAddressBits-1:0] readAddress;
  logic                       clearRequest;
  logic [nrOfDataBits-1:0]    readDataW;
  logic [nrOfDataBits-1:0]    readDataR;
  logic                       busy;

  modport master (
    output writeEnable, byteEnable, writeAddress, writeData,
    output readEnable, readAddress, clearRequest,
    input  readDataW, readDataR, busy
  );

  modport slave (
    input  writeEnable, byteEnable, writeAddress, writeData,
    input  readEnable, readAddress, clearRequest,
    output readDataW, readDataR, busy
  );
endinterface

// File: rtl/sram_sdp_init.sv
// Simple dual-port byte-masked SRAM with a self-clearing init pass; 1-cycle read latency, no backpressure (busy blocks writes).
// SRAM_SDP_BYPASS_EN: same-address read returns the byte-merged new word instead of the old word.
module sram_sdp_init #(
  parameter int                      nrOfAddressBits = 5,
  parameter int                      nrOfDataBits    = 32,
  parameter logic [nrOfDataBits-1:0] initValue       = '0
) (
  input  logic          clock,
  input  logic          reset,
  sram_sdp_init_if.slave bus
);
  localparam int                   DEPTH = 2 ** nrOfAddressBits;
  localparam int                   NB    = nrOfDataBits / 8;
  localparam logic [nrOfAddressBits:0] LAST_ADDR = (nrOfAddressBits + 1)'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                     state_q, state_d;
  logic [nrOfAddressBits:0]   count_q, count_d;
  logic                       busy_q, busy_d;

  logic [nrOfDataBits-1:0]    mem [DEPTH];
  logic [NB-1:0]              lane_we;
  logic [nrOfAddressBits-1:0] wr_addr;
  logic [nrOfDataBits-1:0]    wr_data;
  logic [nrOfDataBits-1:0]    rd_word;
  logic [nrOfDataBits-1:0]    rdata_w_q;
  logic [nrOfDataBits-1:0]    rdata_r_q;
  logic                       clearing;

  assign clearing = (state_q == CLEAR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      count_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  // Clear requests arriving mid-pass are dropped; only IDLE can restart a pass.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    case (state_q)
      CLEAR: begin
        count_d = count_q + 1'b1;
        if (count_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE: begin
        if (bus.clearRequest) begin
          state_d = CLEAR;
          count_d = '0;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        count_d = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // One shared write port: the clear pass owns it while busy, the user otherwise.
  always_comb begin
    lane_we = '0;
    wr_addr = bus.writeAddress;
    wr_data = bus.writeData;
    if (!reset) begin
      if (clearing) begin
        lane_we = '1;
        wr_addr = count_q[nrOfAddressBits-1:0];
        wr_data = initValue;
      end else if (bus.writeEnable) begin
        lane_we = bus.byteEnable;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int b = 0; b < NB; b++) begin
      if (lane_we[b]) begin
        mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[bus.readAddress];
`ifdef SRAM_SDP_BYPASS_EN
    if (bus.writeEnable && (bus.writeAddress == bus.readAddress)) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.byteEnable[b]) begin
          rd_word[8*b +: 8] = bus.writeData[8*b +: 8];
        end
      end
    end
`endif
  end

  // Outputs are forced to zero for the whole time busy is (or is about to be) high.
  always_ff @(posedge clock) begin
    if (reset || clearing || bus.clearRequest) begin
      rdata_w_q <= '0;
      rdata_r_q <= '0;
    end else begin
      rdata_w_q <= mem[bus.writeAddress];
      if (bus.readEnable) begin
        rdata_r_q <= rd_word;
      end
    end
  end

  assign bus.readDataW = rdata_w_q;
  assign bus.readDataR = rdata_r_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sram_sdp_init.sv
// Directed + random bench for sram_sdp_init against an array-based reference model.
module tb_sram_sdp_init;
  localparam int          AW    = 4;
  localparam int          DW    = 32;
  localparam int          NB    = DW / 8;
  localparam int          DEPTH = 16;
  localparam logic [31:0] INIT  = 32'h0000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_sdp_init_if #(.nrOfAddressBits(AW), .nrOfDataBits(DW)) bus ();

  sram_sdp_init #(.nrOfAddressBits(AW), .nrOfDataBits(DW), .initValue(INIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem_m [DEPTH];
  int          clear_left = 0;
  logic [31:0] exp_r = '0;
  logic [31:0] exp_w = '0;
  logic        exp_busy = 1'b1;
  int          n_asserts = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Model advances one clock from the inputs applied now, then the DUT is compared 1ns after the edge.
  task automatic tick();
    logic [31:0] old_w, rd;
    exp_busy = 1'b0;
    if (reset) begin
      clear_left = DEPTH;
      exp_busy   = 1'b1;
      exp_r      = '0;
      exp_w      = '0;
    end else if (clear_left > 0) begin
      mem_m[DEPTH - clear_left] = INIT;
      clear_left--;
      exp_busy = (clear_left > 0);
      exp_r    = '0;
      exp_w    = '0;
    end else begin
      old_w = mem_m[bus.writeAddress];
      rd    = mem_m[bus.readAddress];
`ifdef SRAM_SDP_BYPASS_EN
      if (bus.writeEnable && bus.writeAddress == bus.readAddress)
        for (int b = 0; b < NB; b++)
          if (bus.byteEnable[b]) rd[8*b +: 8] = bus.writeData[8*b +: 8];
`endif
      if (bus.writeEnable)
        for (int b = 0; b < NB; b++)
          if (bus.byteEnable[b]) mem_m[bus.writeAddress][8*b +: 8] = bus.writeData[8*b +: 8];
      if (bus.clearRequest) begin
        clear_left = DEPTH;
        exp_busy   = 1'b1;
        exp_r      = '0;
        exp_w      = '0;
      end else begin
        exp_w = old_w;
        if (bus.readEnable) exp_r = rd;
      end
    end
    @(posedge clock);
    #1;
    check("busy", {31'b0, bus.busy}, {31'b0, exp_busy});
    check("readDataR", bus.readDataR, exp_r);
    check("readDataW", bus.readDataW, exp_w);
  endtask

  task automatic idle_inputs();
    bus.writeEnable  = 1'b0;
    bus.byteEnable   = '0;
    bus.writeAddress = '0;
    bus.writeData    = '0;
    bus.readEnable   = 1'b0;
    bus.readAddress  = '0;
    bus.clearRequest = 1'b0;
  endtask

  initial begin
    int cnt;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;
    idle_inputs();

    // Reset state and initial clear pass length
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("busy_len_after_reset", cnt, 16);

    for (int i = 0; i < DEPTH; i++) begin
      bus.readEnable  = 1'b1;
      bus.readAddress = AW'(i);
      tick();
      check("init_read", bus.readDataR, 32'h0);
    end
    idle_inputs();

    // Full and partial byte-lane writes
    bus.writeEnable = 1'b1; bus.writeAddress = 4'd3; bus.writeData = 32'hDEAD_BEEF; bus.byteEnable = 4'b1111;
    tick();
    idle_inputs();
    bus.readEnable = 1'b1; bus.readAddress = 4'd3;
    tick();
    check("full_write", bus.readDataR, 32'hDEAD_BEEF);
    idle_inputs();
    bus.writeEnable = 1'b1; bus.writeAddress = 4'd3; bus.writeData = 32'h1122_3344; bus.byteEnable = 4'b0101;
    tick();
    idle_inputs();
    bus.readEnable = 1'b1; bus.readAddress = 4'd3;
    tick();
    check("lane_write", bus.readDataR, 32'hDE22_BE44);

    // byteEnable all zero leaves the word unchanged
    idle_inputs();
    bus.writeEnable = 1'b1; bus.writeAddress = 4'd3; bus.writeData = 32'hFFFF_FFFF; bus.byteEnable = 4'b0000;
    tick();
    idle_inputs();
    bus.readEnable = 1'b1; bus.readAddress = 4'd3;
    tick();
    check("zero_be", bus.readDataR, 32'hDE22_BE44);

    // Same-address read during write
    idle_inputs();
    bus.writeEnable = 1'b1; bus.writeAddress = 4'd3; bus.writeData = 32'hDEAD_BEEF; bus.byteEnable = 4'b1111;
    tick();
    bus.writeData = 32'h0000_0000; bus.readEnable = 1'b1; bus.readAddress = 4'd3;
    tick();
    check("rdw_readDataW", bus.readDataW, 32'hDEAD_BEEF);
`ifdef SRAM_SDP_BYPASS_EN
    check("rdw_readDataR", bus.readDataR, 32'h0000_0000);
`else
    check("rdw_readDataR", bus.readDataR, 32'hDEAD_BEEF);
`endif

    // Runtime clear with a write attempted while busy
    idle_inputs();
    bus.writeEnable = 1'b1; bus.writeAddress = 4'd5; bus.writeData = 32'hA5A5_A5A5; bus.byteEnable = 4'b1111;
    tick();
    idle_inputs();
    bus.clearRequest = 1'b1;
    tick();
    bus.clearRequest = 1'b0;
    bus.writeEnable = 1'b1; bus.writeAddress = 4'd5; bus.writeData = 32'hFFFF_FFFF; bus.byteEnable = 4'b1111;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("busy_len_clear", cnt, 16);
    idle_inputs();
    bus.readEnable = 1'b1; bus.readAddress = 4'd5;
    tick();
    check("addr5_cleared", bus.readDataR, 32'h0);

    // Reset in the middle of a clear pass restarts it
    idle_inputs();
    bus.clearRequest = 1'b1;
    tick();
    bus.clearRequest = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check("busy_len_restart", cnt, 16);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      bus.writeEnable  = 1'($urandom_range(0, 1));
      bus.byteEnable   = 4'($urandom);
      bus.writeAddress = 4'($urandom);
      bus.writeData    = $urandom;
      bus.readEnable   = 1'($urandom_range(0, 1));
      bus.readAddress  = ($urandom_range(0, 3) == 0) ? bus.writeAddress : 4'($urandom);
      bus.clearRequest = ($urandom_range(0, 39) == 0);
      reset            = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule
